busarb: RTL
===========

BUSARB -- requirements
Module: busarb

Interface
REQ-001 Parameter: MAX_BURST, default 4; max consecutive m0 grants while m1 waits (1..15).
REQ-002 Parameter: RR, default 0; 0 = m0 priority with MAX_BURST limit, 1 = strict round-robin.
REQ-003 clk  in  1  system clock; sole clock domain.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 mN_en  in  1  master N (N=0 cpu, N=1 dma) requests a bus cycle.
REQ-006 mN_wr  in  1  master N write (1) / read (0).
REQ-007 mN_size  in  2  master N transfer size code, passed through.
REQ-008 mN_addr  in  32  master N address.
REQ-009 mN_data_out  in  32  master N write data.
REQ-010 mN_data_in  out  32  read data to master N.
REQ-011 mN_wt  out  1  wait to master N; 0 only in the completing cycle of a granted request.
REQ-012 bus_en, bus_wr  out  1 each  to bus controller.
REQ-013 bus_size  out  2; bus_addr  out  32; bus_data_out  out  32; all to bus controller.
REQ-014 bus_data_in  in  32  read data from bus controller.
REQ-015 bus_wt  in  1  wait from bus controller.
REQ-016 gnt  out  2  one-hot current grant {m1,m0}; 00 when idle.

Function
REQ-017 FSM states: IDLE, G0 (m0 owns bus), G1 (m1 owns bus); state register and burst counter only.
REQ-018 IDLE: bus_en=0, all mN_wt=1, gnt=00; next state decided from mN_en sampled this cycle (1-cycle arbitration latency).
REQ-019 IDLE arbitration: only one requester -> grant it; both -> RR=1: master not served last, RR=0: m0 unless burst counter = MAX_BURST, then m1.
REQ-020 In GN: bus_en/wr/size/addr/data_out = master N signals combinationally; mN_wt = bus_wt; other master's wt = 1.
REQ-021 Both mN_data_in = bus_data_in always (broadcast; only meaningful with wt=0).
REQ-022 Completion = GN & mN_en & ~bus_wt; on completion: other master's en=1 and eligible per REQ-019 -> grant it directly next cycle; else if mN_en still requested -> stay GN only when other master not requesting; else IDLE.
REQ-023 RR=1: completion with other master requesting always switches grant.
REQ-024 Burst counter: +1 on each m0 completion while m1_en=1, saturating at MAX_BURST; cleared on any m1 grant or when m1_en=0.
REQ-025 Granted master drops en before completion (abort) -> IDLE next cycle, no counter change.
REQ-026 bus_en never asserted in IDLE; grant never changes while bus_wt=1 and owner's en=1.
REQ-027 Last-served flag (for RR) updates on each completion.

Reset
REQ-028 Reset asserted (any cycle, including mid-transfer) -> immediately IDLE, gnt=00, bus_en=0, mN_wt=1, burst counter=0, last-served=m1 (so m0 wins first RR tie).
REQ-029 First arbitration occurs on the first rising clk edge after reset deasserts.

Structure
REQ-030 State encoding and grant constants in shared package eco32_bus_pkg; MAX_BURST/RR as module parameters.
REQ-031 One sub-module natural: busarb_pick (combinational next-grant selector); datapath muxes stay in busarb.

Verification
REQ-032 Only m0_en=1, addr 0xE0000000, bus_wt low after 2 cycles -> gnt=01 one cycle after request, m0_wt=0 exactly in cycle 3 of grant, m1_wt=1 throughout.
REQ-033 Both request same cycle, RR=1, repeated back-to-back -> gnt alternates 01,10,01,10 with no IDLE cycle between completions.
REQ-034 RR=0, MAX_BURST=4, both request continuously, bus_wt=0 -> four m0 completions, then one m1 completion, pattern repeats.
REQ-035 m1 granted, bus_wt=1, m1_en dropped -> IDLE next cycle, bus_en=0, m0 (requesting) granted following cycle.
REQ-036 Reset asserted mid-G0 with bus_wt=1 -> same-cycle bus_en=0, gnt=00; after release m0 re-arbitrates with 1-cycle latency.
REQ-037 Read of 0x12345678 via m1 -> m1_data_in=0x12345678 when m1_wt=0; m0_wt stays 1.

Source files
------------

// File: rtl/eco32_bus_pkg.sv
// eco32_bus_pkg: arbiter state encoding and one-hot grant constants shared by busarb
package eco32_bus_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, G0 = 2'b01, G1 = 2'b10} arb_state_t;
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0 = 2'b01;
    localparam logic [1:0] GNT_M1 = 2'b10;
endpackage

// File: rtl/busarb_pick.sv
// busarb_pick: combinational next-grant selector with burst counter and last-served updates
module busarb_pick
    import eco32_bus_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter bit RR = 1'b0
) (
    input  arb_state_t state,
    input  logic       m0_en,
    input  logic       m1_en,
    input  logic       bus_wt,
    input  logic [3:0] burst,
    input  logic       last,
    output arb_state_t state_n,
    output logic [3:0] burst_n,
    output logic       last_n
);
    localparam logic [3:0] MB = 4'(MAX_BURST);
    logic own_en, oth_en, done, tie_m1;
    logic [3:0] burst_inc;
    arb_state_t other;
    always_comb begin
        own_en = state == G1 ? m1_en : m0_en;
        oth_en = state == G1 ? m0_en : m1_en;
        other = state == G0 ? G1 : G0;
        done = state != IDLE && own_en && !bus_wt;
        last_n = done ? state == G1 : last;
        burst_inc = state == G0 && done && m1_en && burst != MB ? burst + 4'd1 : burst;
        // tie winner is judged on this cycle's updated counter and last-served flag
        tie_m1 = RR ? !last_n : burst_inc == MB;
        if (state == IDLE)
            state_n = m0_en && m1_en ? (tie_m1 ? G1 : G0) : m0_en ? G0 : m1_en ? G1 : IDLE;
        else if (!own_en)
            state_n = IDLE;
        else if (bus_wt || !oth_en)
            state_n = state;
        else
            state_n = tie_m1 == (state == G0) ? other : IDLE;
        burst_n = !m1_en || state_n == G1 ? 4'd0 : burst_inc;
    end
endmodule

// File: rtl/busarb.sv
// busarb: two-master bus arbiter (m0 cpu, m1 dma) with burst-limited priority or round-robin
module busarb
    import eco32_bus_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter bit RR = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_en,
    input  logic        m0_wr,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_data_out,
    output logic [31:0] m0_data_in,
    output logic        m0_wt,
    input  logic        m1_en,
    input  logic        m1_wr,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_data_out,
    output logic [31:0] m1_data_in,
    output logic        m1_wt,
    output logic        bus_en,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_data_out,
    input  logic [31:0] bus_data_in,
    input  logic        bus_wt,
    output logic [1:0]  gnt
);
    arb_state_t state, state_n;
    logic [3:0] burst, burst_n;
    logic last, last_n, sel1;
    busarb_pick #(.MAX_BURST(MAX_BURST), .RR(RR)) u_pick (
        .state(state), .m0_en(m0_en), .m1_en(m1_en), .bus_wt(bus_wt),
        .burst(burst), .last(last),
        .state_n(state_n), .burst_n(burst_n), .last_n(last_n)
    );
    // last starts at m1 so m0 wins the first round-robin tie
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            burst <= 4'd0;
            last <= 1'b1;
        end else begin
            state <= state_n;
            burst <= burst_n;
            last <= last_n;
        end
    assign sel1 = state == G1;
    assign bus_en = state == G0 ? m0_en : sel1 && m1_en;
    assign bus_wr = sel1 ? m1_wr : m0_wr;
    assign bus_size = sel1 ? m1_size : m0_size;
    assign bus_addr = sel1 ? m1_addr : m0_addr;
    assign bus_data_out = sel1 ? m1_data_out : m0_data_out;
    assign m0_wt = state == G0 ? bus_wt : 1'b1;
    assign m1_wt = sel1 ? bus_wt : 1'b1;
    assign m0_data_in = bus_data_in;
    assign m1_data_in = bus_data_in;
    assign gnt = state == G0 ? GNT_M0 : sel1 ? GNT_M1 : GNT_NONE;
endmodule
